// File: rtl/par_to_ser_lanes.sv
// par_to_ser_lanes: captures an N-word vector and replays it as ceil(len/Lanes)
// beats of Lanes words. Supports a runtime length, reversed order, a per-lane
// keep mask and a last flag. Output beats are fully registered. A new vector
// is reloaded on the cycle its predecessor's last beat is taken, so there is
// no bubble between vectors.
module par_to_ser_lanes #(
  parameter  int Width = 16,
  parameter  int N     = 8,
  parameter  int Lanes = 1,
  localparam int LW    = $clog2(N + 1),
  localparam int Beats = N / Lanes,
  localparam int IW    = (Beats > 1) ? $clog2(Beats) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [0:N-1][Width-1:0]       s_data_i,
  input  logic [LW-1:0]                 s_len_i,
  input  logic                          s_rev_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [0:Lanes-1][Width-1:0]   m_data_o,
  output logic [Lanes-1:0]              m_keep_o,
  output logic                          m_last_o,
  output logic [IW-1:0]                 m_idx_o
);

  // Beat counter must be able to hold the beat count itself (up to Beats).
  localparam int BW  = $clog2(Beats + 1);
  localparam int IXW = (N > 1) ? $clog2(N) : 1;

  if ((N < 1) || ((N % Lanes) != 0)) begin : g_bad_params
    $error("par_to_ser_lanes: N must be >= 1 and a multiple of Lanes");
  end

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic                        w_ready;
  logic                        w_accept;
  logic                        w_advance;
  logic                        w_done;

  logic [0:N-1][Width-1:0]     r_buf;
  logic [LW-1:0]               r_len;
  logic                        r_rev;
  logic [BW-1:0]               r_beats;
  logic [BW-1:0]               r_beat;

  logic [LW-1:0]               w_eff_len;
  logic [BW-1:0]               w_eff_beats;

  logic [0:N-1][Width-1:0]     w_src_data;
  logic [LW-1:0]               w_src_len;
  logic                        w_src_rev;
  logic [BW-1:0]               w_src_beats;
  logic [BW-1:0]               w_src_beat;

  logic [0:Lanes-1][Width-1:0] w_beat_data;
  logic [Lanes-1:0]            w_beat_keep;

  logic [0:Lanes-1][Width-1:0] r_m_data;
  logic [Lanes-1:0]            r_m_keep;
  logic                        r_m_last;
  logic [IW-1:0]               r_m_idx;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and input-ready; ready follows m_ready_i combinationally so the
  // next vector can be taken in the same cycle the last beat leaves.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (s_valid_i) begin
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_ready = m_ready_i & r_m_last;
        if (m_ready_i & r_m_last) begin
          if (s_valid_i) begin
            w_next_state = ST_SHIFT;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_ready      = 1'b0;
      end
    endcase
  end

  assign s_ready_o = w_ready & ~rst_i;
  assign w_accept  = s_valid_i & s_ready_o;
  assign w_advance = (r_state == ST_SHIFT) & m_ready_i & ~r_m_last;
  assign w_done    = (r_state == ST_SHIFT) & m_ready_i & r_m_last;

  // Effective length: 0 or anything above N means a full vector.
  always_comb begin
    if ((s_len_i == {LW{1'b0}}) || (s_len_i > LW'(N))) begin
      w_eff_len = LW'(N);
    end else begin
      w_eff_len = s_len_i;
    end
    w_eff_beats = BW'((int'(w_eff_len) + Lanes - 1) / Lanes);
  end

  // Select what the next registered beat is built from: the incoming vector
  // on accept (beat 0), otherwise the captured vector at the following beat.
  always_comb begin
    if (w_accept) begin
      w_src_data  = s_data_i;
      w_src_len   = w_eff_len;
      w_src_rev   = s_rev_i;
      w_src_beats = w_eff_beats;
      w_src_beat  = {BW{1'b0}};
    end else begin
      w_src_data  = r_buf;
      w_src_len   = r_len;
      w_src_rev   = r_rev;
      w_src_beats = r_beats;
      w_src_beat  = r_beat + BW'(1);
    end
  end

  // Lane mux: lane k of beat b carries sequence position p = b*Lanes + k,
  // which is word p (normal) or word len-1-p (reversed); lanes past len are blank.
  always_comb begin
    int               v_pos;
    logic [IXW-1:0]   v_word;
    v_pos       = 0;
    v_word      = {IXW{1'b0}};
    w_beat_data = {(Lanes * Width){1'b0}};
    w_beat_keep = {Lanes{1'b0}};
    for (int k = 0; k < Lanes; k++) begin
      v_pos = int'(w_src_beat) * Lanes + k;
      if (v_pos < int'(w_src_len)) begin
        if (w_src_rev) begin
          v_word = IXW'(int'(w_src_len) - 1 - v_pos);
        end else begin
          v_word = IXW'(v_pos);
        end
        w_beat_keep[k] = 1'b1;
        w_beat_data[k] = w_src_data[v_word];
      end else begin
        w_beat_keep[k] = 1'b0;
        w_beat_data[k] = {Width{1'b0}};
      end
    end
  end

  // Capture the vector on accept and register each outgoing beat; hold under
  // backpressure and blank the outputs once the final beat has been taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_buf    <= {(N * Width){1'b0}};
      r_len    <= {LW{1'b0}};
      r_rev    <= 1'b0;
      r_beats  <= {BW{1'b0}};
      r_beat   <= {BW{1'b0}};
      r_m_data <= {(Lanes * Width){1'b0}};
      r_m_keep <= {Lanes{1'b0}};
      r_m_last <= 1'b0;
      r_m_idx  <= {IW{1'b0}};
    end else if (w_accept | w_advance) begin
      if (w_accept) begin
        r_buf   <= s_data_i;
        r_len   <= w_eff_len;
        r_rev   <= s_rev_i;
        r_beats <= w_eff_beats;
      end
      r_beat   <= w_src_beat;
      r_m_data <= w_beat_data;
      r_m_keep <= w_beat_keep;
      r_m_last <= (w_src_beat == (w_src_beats - BW'(1)));
      r_m_idx  <= IW'(w_src_beat);
    end else if (w_done) begin
      r_m_data <= {(Lanes * Width){1'b0}};
      r_m_keep <= {Lanes{1'b0}};
      r_m_last <= 1'b0;
      r_m_idx  <= {IW{1'b0}};
    end
  end

  assign m_valid_o = (r_state == ST_SHIFT);
  assign m_data_o  = r_m_data;
  assign m_keep_o  = r_m_keep;
  assign m_last_o  = r_m_last;
  assign m_idx_o   = r_m_idx;

endmodule

// File: tb/tb_par_to_ser_lanes.sv
// Bench for par_to_ser_lanes: two instances (Lanes=1 and Lanes=2, N=8) driven
// by directed and random vectors. A reference model turns each accepted
// vector into a list of expected beats in a queue; per-instance monitors
// compare every presented beat against the queue head.
module tb_par_to_ser_lanes;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  keep;
    logic        last;
    int          idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b0;

  logic              s1_valid, s1_ready, s1_rev;
  logic [0:7][15:0]  s1_data;
  logic [3:0]        s1_len;
  logic              m1_valid, m1_ready, m1_last;
  logic [0:0][15:0]  m1_data;
  logic [0:0]        m1_keep;
  logic [2:0]        m1_idx;

  logic              s2_valid, s2_ready, s2_rev;
  logic [0:7][15:0]  s2_data;
  logic [3:0]        s2_len;
  logic              m2_valid, m2_ready, m2_last;
  logic [0:1][15:0]  m2_data;
  logic [1:0]        m2_keep;
  logic [1:0]        m2_idx;

  beat_t exp1[$];
  beat_t exp2[$];
  int    checks = 0;
  int    errors = 0;
  int    pop1 = 0;
  int    rmode = 0;

  par_to_ser_lanes #(.Width(16), .N(8), .Lanes(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s1_valid), .s_ready_o(s1_ready),
    .s_data_i(s1_data), .s_len_i(s1_len), .s_rev_i(s1_rev),
    .m_valid_o(m1_valid), .m_ready_i(m1_ready), .m_data_o(m1_data),
    .m_keep_o(m1_keep), .m_last_o(m1_last), .m_idx_o(m1_idx)
  );

  par_to_ser_lanes #(.Width(16), .N(8), .Lanes(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s2_valid), .s_ready_o(s2_ready),
    .s_data_i(s2_data), .s_len_i(s2_len), .s_rev_i(s2_rev),
    .m_valid_o(m2_valid), .m_ready_i(m2_ready), .m_data_o(m2_data),
    .m_keep_o(m2_keep), .m_last_o(m2_last), .m_idx_o(m2_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= rst;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: order the first L words (reversed if asked), then cut
  // the sequence into beats of 'lanes' words, padding the tail with blanks.
  task automatic push_vec(input int which, input logic [0:7][15:0] d,
                          input logic [3:0] len, input logic rev);
    int          l;
    int          lanes;
    int          nb;
    logic [15:0] seq[$];
    beat_t       e;
    l = ((len == 4'd0) || (len > 4'd8)) ? 8 : int'(len);
    for (int i = 0; i < l; i++) seq.push_back(rev ? d[l - 1 - i] : d[i]);
    lanes = (which == 1) ? 1 : 2;
    nb = (l + lanes - 1) / lanes;
    for (int b = 0; b < nb; b++) begin
      e.d0   = seq[b * lanes];
      e.d1   = 16'h0000;
      e.keep = 2'b01;
      if ((lanes == 2) && (b * 2 + 1 < l)) begin
        e.d1   = seq[b * 2 + 1];
        e.keep = 2'b11;
      end
      e.last = (b == nb - 1);
      e.idx  = b;
      if (which == 1) exp1.push_back(e);
      else            exp2.push_back(e);
    end
  endtask

  // Present a vector, wait (bounded) for the handshake, then scramble inputs.
  task automatic send(input int which, input logic [0:7][15:0] d,
                      input logic [3:0] len, input logic rev);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    if (which == 1) begin
      s1_valid = 1'b1; s1_data = d; s1_len = len; s1_rev = rev;
    end else begin
      s2_valid = 1'b1; s2_data = d; s2_len = len; s2_rev = rev;
    end
    while (!acc && (n < 300)) begin
      @(negedge clk);
      acc = (which == 1) ? (s1_ready === 1'b1) : (s2_ready === 1'b1);
      cyc();
      n++;
    end
    if (acc) begin
      push_vec(which, d, len, rev);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut=%0d actual=0 required=1", which);
    end
    if (which == 1) begin
      s1_valid = 1'b0; s1_len = 4'($urandom); s1_rev = 1'($urandom);
      for (int i = 0; i < 8; i++) s1_data[i] = 16'($urandom);
    end else begin
      s2_valid = 1'b0; s2_len = 4'($urandom); s2_rev = 1'($urandom);
      for (int i = 0; i < 8; i++) s2_data[i] = 16'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((exp1.size() != 0) || (exp2.size() != 0)) && (n < 400)) begin
      cyc();
      n++;
    end
    if ((exp1.size() != 0) || (exp2.size() != 0)) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp1.size() + exp2.size());
      exp1.delete();
      exp2.delete();
    end
    cyc();
  endtask

  function automatic logic [0:7][15:0] ramp(input int base);
    logic [0:7][15:0] v;
    for (int i = 0; i < 8; i++) v[i] = 16'(base + i);
    return v;
  endfunction

  function automatic logic [0:7][15:0] rnd_vec();
    logic [0:7][15:0] v;
    for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
    return v;
  endfunction

  // Downstream ready pattern: always, toggling, or random.
  initial begin
    m1_ready = 1'b1;
    m2_ready = 1'b1;
    forever begin
      cyc();
      case (rmode)
        1: begin m1_ready = ~m1_ready; m2_ready = ~m2_ready; end
        2: begin m1_ready = 1'($urandom); m2_ready = 1'($urandom); end
        default: begin m1_ready = 1'b1; m2_ready = 1'b1; end
      endcase
    end
  end

  // Monitor, Lanes=1 instance.
  always @(negedge clk) begin
    bit ev;
    if (rst) begin
      if (rst_q) begin
        chk("reset_out1", {m1_valid, m1_data[0], m1_keep, m1_last, m1_idx, s1_ready}, 64'd0);
      end
      exp1.delete();
    end else begin
      ev = (exp1.size() != 0);
      chk("valid1", {63'd0, m1_valid}, {63'd0, ev});
      chk("s_ready1", {63'd0, s1_ready}, {63'd0, (ev ? (m1_ready && exp1[0].last) : 1'b1)});
      if (ev && (m1_valid === 1'b1)) begin
        chk("beat1", {43'd0, m1_data[0], m1_keep, m1_last, m1_idx},
            {43'd0, exp1[0].d0, exp1[0].keep[0], exp1[0].last, 3'(exp1[0].idx)});
        if (m1_ready) begin
          void'(exp1.pop_front());
          pop1++;
        end
      end
    end
  end

  // Monitor, Lanes=2 instance.
  always @(negedge clk) begin
    bit ev;
    if (rst) begin
      if (rst_q) begin
        chk("reset_out2", {m2_valid, m2_data[0], m2_data[1], m2_keep, m2_last, m2_idx, s2_ready}, 64'd0);
      end
      exp2.delete();
    end else begin
      ev = (exp2.size() != 0);
      chk("valid2", {63'd0, m2_valid}, {63'd0, ev});
      chk("s_ready2", {63'd0, s2_ready}, {63'd0, (ev ? (m2_ready && exp2[0].last) : 1'b1)});
      if (ev && (m2_valid === 1'b1)) begin
        chk("beat2", {27'd0, m2_data[0], m2_data[1], m2_keep, m2_last, m2_idx},
            {27'd0, exp2[0].d0, exp2[0].d1, exp2[0].keep, exp2[0].last, 2'(exp2[0].idx)});
        if (m2_ready) void'(exp2.pop_front());
      end
    end
  end

  initial begin
    int base;
    int n;
    s1_valid = 1'b0; s1_data = '0; s1_len = 4'd0; s1_rev = 1'b0;
    s2_valid = 1'b0; s2_data = '0; s2_len = 4'd0; s2_rev = 1'b0;

    // Reset held for three clocks.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // Back-to-back streaming, Lanes=1.
    send(1, ramp(0), 4'd8, 1'b0);
    send(1, ramp(1), 4'd8, 1'b0);
    drain();

    // Lanes=2, partial length.
    send(2, ramp(10), 4'd5, 1'b0);
    drain();

    // Reverse order, short and full (len=0).
    send(1, ramp(10), 4'd3, 1'b1);
    send(1, ramp(10), 4'd0, 1'b1);
    drain();

    // Toggling backpressure.
    rmode = 1;
    send(1, rnd_vec(), 4'd8, 1'b0);
    send(1, rnd_vec(), 4'd8, 1'b1);
    send(2, rnd_vec(), 4'd7, 1'b1);
    drain();
    rmode = 0;
    cyc();

    // Reset while beat 3 is on the output.
    base = pop1;
    send(1, ramp(40), 4'd8, 1'b0);
    n = 0;
    while (((pop1 - base) < 3) && (n < 50)) begin
      cyc();
      n++;
    end
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    send(1, ramp(60), 4'd4, 1'b1);
    drain();

    // Random vectors on both instances with mixed ready patterns.
    for (int t = 0; t < 40; t++) begin
      rmode = int'($urandom_range(0, 2));
      send(int'($urandom_range(1, 2)), rnd_vec(), 4'($urandom_range(0, 15)), 1'($urandom));
      repeat ($urandom_range(0, 2)) cyc();
    end
    rmode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
